hart_meter: RTL and testbench
=============================

// Module: hart_meter
// PURPOSE
//  Upstream stage of the stress detector. Turns the raw heartbeat sensor pulse into the 6-bit
//  heart-rate word `hart` consumed by the stress-delta stage. Beats are counted per fixed
//  window of `slow` ticks, and `hart` is held stable for the whole next window, so the
//  downstream equality check settles. Also flags loss of signal.
// PARAMETERS
//  WINDOW      600  slow ticks per measurement window (>=8)
//  REFRACT     20   slow ticks after an accepted beat during which further edges are ignored (>=1)
//  SYNC_STAGES 2    flops in the beat input synchroniser (>=2)
// PORTS
//  slow      in   1  clock, all logic on posedge
//  reset     in   1  asynchronous, active-low; low clears all state immediately
//  beat      in   1  raw sensor pulse, asynchronous to slow, arbitrary width
//  hart      out  6  beats counted in the last completed window, saturated to 63
//  nieuw     out  1  one-cycle pulse in the cycle `hart` is updated
//  beatPuls  out  1  one-cycle pulse per accepted beat
//  geenHart  out  1  high while the last completed window contained zero beats
// BEHAVIOUR
//  - Reset (reset=0): hart=0, nieuw=0, beatPuls=0, geenHart=0. Window counter, beat counter,
//    refractory counter and FSM are cleared. Sync chain is cleared to 0. The edge-detect
//    history flop is set to 1, so a beat held high across reset release is NOT counted.
//  - Input path: beat -> SYNC_STAGES flops -> rising-edge detect (sync & ~prev).
//  - Refractory FSM:
//    ARMED: edge -> beatPuls=1 next cycle, refr cnt=REFRACT-1, go BLANK.
//    BLANK: edges ignored; cnt decrements each cycle; at cnt==0 return to ARMED.
//    An edge in the first ARMED cycle after BLANK is accepted.
//  - Latency: beat rising edge to beatPuls high = SYNC_STAGES+1 cycles, exactly 1 cycle wide.
//  - Window counter runs 0..WINDOW-1 and wraps. Width $clog2(WINDOW).
//  - Beat counter is 6-bit and saturates at 63; it increments on each beatPuls.
//  - Terminal cycle (window cnt==WINDOW-1):
//    next cycle hart<=count (or the average, see CONFIGURATION) and nieuw=1;
//    geenHart<=(count==0); beat counter restarts at 0.
//  - Simultaneous events: a beatPuls in the terminal cycle counts toward the NEXT window
//    (counter loads 1, not 0). Saturation wins over increment.
//  - hart, geenHart: change only in the nieuw cycle; otherwise held.
//  - Reset mid-window: the partial count is discarded and the window restarts at 0 after release.
// CONFIGURATION
//  HART_AVG_EN defined:
//    - Keep a 4-entry history of saturated window counts, reset to 0.
//    - On update, hart = (sum of last 4 incl. current) >> 2 (8-bit sum, truncating shift).
//    - Hence ramp-up over the first 4 windows after reset.
//    - geenHart still uses the raw current window count.
//  HART_AVG_EN undefined:
//    - hart = raw window count. No history registers.
// TESTING (WINDOW=100, REFRACT=3, SYNC_STAGES=2 unless stated)
//  1. reset low mid-run, beat toggling -> all outputs 0 while low; beat held high at
//     release -> no beatPuls.
//  2. 2-cycle beat pulse every 5 ticks -> beatPuls every 5 cycles, 3 cycles after each edge;
//     after window 1: hart=20, single-cycle nieuw; hart stable for next 100 cycles.
//  3. two edges 2 ticks apart, then a third 4 ticks after the first -> beatPuls for edges
//     1 and 3 only.
//  4. WINDOW=400, beat every 4 ticks (100 beats) -> hart=63, no wrap to 36.
//  5. one full window with beat=0 -> hart=0, geenHart=1; next window with 10 beats -> hart=10,
//     geenHart=0.
//  6. beatPuls forced in terminal cycle -> counted in following window. HART_AVG_EN:
//     steady 20/window -> hart=5, 10, 15, 20, 20.

Source files
------------

// File: rtl/hart_meter.sv
// Heart-rate meter: synchronises the raw beat pulse, applies a refractory blanking period and
// counts accepted beats per window. Optional macro HART_AVG_EN averages the last four windows.
module hart_meter #(
  parameter int unsigned WINDOW      = 600,
  parameter int unsigned REFRACT     = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       beat,
  output logic [5:0] hart,
  output logic       nieuw,
  output logic       beatPuls,
  output logic       geenHart
);

  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned RefW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
  localparam logic [RefW-1:0] RefLoad = RefW'(REFRACT - 1);

  typedef enum logic {StArmed, StBlank} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   prev_q;
  logic                   beat_sync;
  logic                   rise;

  state_e                 state_q, state_d;
  logic [RefW-1:0]        refr_q, refr_d;
  logic                   puls_q, puls_d;

  logic [WinW-1:0]        win_q, win_d;
  logic                   term;
  logic [5:0]             cnt_q, cnt_d;
  logic [5:0]             hart_q, hart_d;
  logic                   nieuw_q;
  logic                   geen_q, geen_d;
  logic [5:0]             new_hart;

  assign beat_sync = sync_q[SYNC_STAGES-1];
  assign rise      = beat_sync & ~prev_q;

  // prev stays 1 until the chain has filled, so a beat already high at release is not an edge
  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prime_q <= '0;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], beat};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= prime_q[SYNC_STAGES-1] ? beat_sync : 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    refr_d  = refr_q;
    puls_d  = 1'b0;
    unique case (state_q)
      StArmed: begin
        if (rise) begin
          puls_d  = 1'b1;
          refr_d  = RefLoad;
          state_d = StBlank;
        end
      end
      StBlank: begin
        if (refr_q == '0) begin
          state_d = StArmed;
        end else begin
          refr_d = refr_q - 1'b1;
        end
      end
      default: state_d = StArmed;
    endcase
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      state_q <= StArmed;
      refr_q  <= '0;
      puls_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      refr_q  <= refr_d;
      puls_q  <= puls_d;
    end
  end

  assign term  = (win_q == WinLast);
  assign win_d = term ? '0 : win_q + 1'b1;

  // A beat landing in the terminal cycle opens the next window's count
  always_comb begin
    cnt_d = cnt_q;
    if (term) begin
      cnt_d = {5'd0, puls_q};
    end else if (puls_q && (cnt_q != 6'd63)) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

`ifdef HART_AVG_EN
  logic [5:0] hist0_q, hist1_q, hist2_q;
  logic [7:0] sum;

  assign sum      = {2'd0, cnt_q} + {2'd0, hist0_q} + {2'd0, hist1_q} + {2'd0, hist2_q};
  assign new_hart = sum[7:2];

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (term) begin
      hist0_q <= cnt_q;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign new_hart = cnt_q;
`endif

  always_comb begin
    hart_d = hart_q;
    geen_d = geen_q;
    if (term) begin
      hart_d = new_hart;
      geen_d = (cnt_q == 6'd0);
    end
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      cnt_q   <= '0;
      hart_q  <= '0;
      nieuw_q <= 1'b0;
      geen_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      hart_q  <= hart_d;
      nieuw_q <= term;
      geen_q  <= geen_d;
    end
  end

  assign hart     = hart_q;
  assign nieuw    = nieuw_q;
  assign beatPuls = puls_q;
  assign geenHart = geen_q;

endmodule

// File: tb/tb_hart_meter.sv
// Scoreboard bench for hart_meter: expected beatPuls cycles are queued as beats are driven and
// expected window words are derived from the bench's own per-window beat tally.
module tb_hart_meter;

  localparam int Window  = 100;
  localparam int Refract = 3;
  localparam int Sync    = 2;

  logic       slow = 1'b0;
  logic       reset = 1'b0;
  logic       beat = 1'b0;
  logic [5:0] hart;
  logic       nieuw, beatPuls, geenHart;

  logic       reset2 = 1'b0;
  logic       beat2 = 1'b0;
  logic [5:0] hart2;
  logic       nieuw2, puls2, geen2;

  hart_meter #(.WINDOW(Window), .REFRACT(Refract), .SYNC_STAGES(Sync)) u_dut (
    .slow(slow), .reset(reset), .beat(beat),
    .hart(hart), .nieuw(nieuw), .beatPuls(beatPuls), .geenHart(geenHart)
  );

  hart_meter #(.WINDOW(400), .REFRACT(Refract), .SYNC_STAGES(Sync)) u_dut_sat (
    .slow(slow), .reset(reset2), .beat(beat2),
    .hart(hart2), .nieuw(nieuw2), .beatPuls(puls2), .geenHart(geen2)
  );

  always #5 slow = ~slow;

  int cyc = 0;
  always @(posedge slow) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  bit         running = 1'b0;
  int         rel_cyc = 0;
  int         last_acc = -1000;
  int         puls_seen = 0;
  int         exp_puls[$];
  int         win_cnt[int];
  logic [5:0] exp_hart = '0;
  logic       exp_geen = 1'b0;
  int         hist[3];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge slow);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  // Called just as beat rises; accepted edges must be at least Refract+1 cycles apart
  task automatic push_edge();
    int k, w;
    if (cyc - last_acc >= Refract + 1) begin
      k = cyc + Sync + 1;
      exp_puls.push_back(k);
      last_acc = cyc;
      w = (k - rel_cyc + 1) / Window + 1;
      if (win_cnt.exists(w)) win_cnt[w] = win_cnt[w] + 1;
      else win_cnt[w] = 1;
    end
  endtask

  task automatic pulse(input int high, input int low);
    beat = 1'b1;
    push_edge();
    tick(high);
    beat = 1'b0;
    tick(low);
  endtask

  task automatic apply_reset(input int low_cycles, input logic beat_at_release);
    reset    = 1'b0;
    running  = 1'b0;
    exp_puls.delete();
    win_cnt.delete();
    exp_hart = '0;
    exp_geen = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
    last_acc = -1000;
    for (int i = 0; i < low_cycles; i++) begin
      beat = ~beat;
      tick(1);
    end
    beat = beat_at_release;
    tick(2);
    reset   = 1'b1;
    rel_cyc = cyc;
    running = 1'b1;
  endtask

  // Cycle monitor for the main DUT
  initial begin
    int   w, n, sat, sum;
    logic exp_b, upd;
    forever begin
      @(negedge slow);
      if (!reset) begin
        checks++;
        if ({hart, nieuw, beatPuls, geenHart} !== 9'd0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got hart=%0d nieuw=%b beatPuls=%b geenHart=%b want 0",
                   cyc, hart, nieuw, beatPuls, geenHart);
        end
      end else if (running) begin
        if (beatPuls === 1'b1) puls_seen++;
        while (exp_puls.size() > 0 && exp_puls[0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL beatPuls_missing expected at cyc=%0d got none", exp_puls[0]);
          void'(exp_puls.pop_front());
        end
        exp_b = (exp_puls.size() > 0) && (exp_puls[0] == cyc);
        checks++;
        if (beatPuls !== exp_b) begin
          errors++;
          $display("FAIL beatPuls cyc=%0d got %b want %b", cyc, beatPuls, exp_b);
        end
        if (exp_b) void'(exp_puls.pop_front());
        upd = (cyc > rel_cyc) && ((cyc - rel_cyc) % Window == 0);
        if (upd) begin
          w   = (cyc - rel_cyc) / Window;
          n   = win_cnt.exists(w) ? win_cnt[w] : 0;
          sat = (n > 63) ? 63 : n;
          exp_geen = (sat == 0);
`ifdef HART_AVG_EN
          sum = sat + hist[0] + hist[1] + hist[2];
          exp_hart = 6'(sum / 4);
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0] = sat;
`else
          sum = sat;
          exp_hart = 6'(sum);
`endif
        end
        checks++;
        if (nieuw !== upd) begin
          errors++;
          $display("FAIL nieuw cyc=%0d got %b want %b", cyc, nieuw, upd);
        end
        checks++;
        if (hart !== exp_hart || geenHart !== exp_geen) begin
          errors++;
          $display("FAIL hart_word cyc=%0d got hart=%0d geenHart=%b want hart=%0d geenHart=%b",
                   cyc, hart, geenHart, exp_hart, exp_geen);
        end
      end
    end
  end

  task automatic test_reset();
    int seen0;
    apply_reset(12, 1'b1);
    seen0 = puls_seen;
    tick(20);
    checks++;
    if (puls_seen - seen0 !== 0) begin
      errors++;
      $display("FAIL reset_release_high got %0d beatPuls want 0", puls_seen - seen0);
    end
    beat = 1'b0;
    tick(3);
  endtask

  task automatic test_periodic();
    for (int i = 0; i < 100; i++) pulse(2, 3);
  endtask

  task automatic test_refractory();
    int seen0;
    tick(10);
    seen0 = puls_seen;
    pulse(1, 1);
    pulse(1, 1);
    pulse(1, 10);
    checks++;
    if (puls_seen - seen0 !== 2) begin
      errors++;
      $display("FAIL refractory got %0d beatPuls want 2", puls_seen - seen0);
    end
  endtask

  task automatic test_zero_window();
    apply_reset(6, 1'b0);
    wait_cyc(rel_cyc + Window);
    @(negedge slow);
    checks++;
    if (nieuw !== 1'b1 || hart !== 6'd0 || geenHart !== 1'b1) begin
      errors++;
      $display("FAIL empty_window got nieuw=%b hart=%0d geenHart=%b want 1 0 1",
               nieuw, hart, geenHart);
    end
    tick(1);
    for (int i = 0; i < 10; i++) pulse(1, 5);
    wait_cyc(rel_cyc + 2 * Window);
    @(negedge slow);
    checks++;
`ifdef HART_AVG_EN
    if (hart !== 6'd2 || geenHart !== 1'b0) begin
`else
    if (hart !== 6'd10 || geenHart !== 1'b0) begin
`endif
      errors++;
      $display("FAIL ten_beats got hart=%0d geenHart=%b", hart, geenHart);
    end
  endtask

  task automatic test_terminal();
    wait_cyc(rel_cyc + 3 * Window - 4);
    pulse(1, 1);
    wait_cyc(rel_cyc + 3 * Window);
    @(negedge slow);
    checks++;
    if (geenHart !== 1'b1) begin
      errors++;
      $display("FAIL terminal_beat_leak got geenHart=%b want 1", geenHart);
    end
    wait_cyc(rel_cyc + 4 * Window - 5);
    pulse(1, 1);
    wait_cyc(rel_cyc + 4 * Window);
    @(negedge slow);
    checks++;
`ifdef HART_AVG_EN
    if (hart !== 6'd3 || geenHart !== 1'b0) begin
`else
    if (hart !== 6'd2 || geenHart !== 1'b0) begin
`endif
      errors++;
      $display("FAIL terminal_beat_next got hart=%0d geenHart=%b", hart, geenHart);
    end
  endtask

  task automatic test_saturation();
    bit got;
    reset2 = 1'b0;
    tick(3);
    reset2 = 1'b1;
    tick(4);
    for (int i = 0; i < 90; i++) begin
      beat2 = 1'b1;
      tick(1);
      beat2 = 1'b0;
      tick(3);
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge slow);
      if (nieuw2 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sat_nieuw_timeout got no nieuw want one within 200 cycles");
    end
    checks++;
`ifdef HART_AVG_EN
    if (hart2 !== 6'd15 || geen2 !== 1'b0) begin
`else
    if (hart2 !== 6'd63 || geen2 !== 1'b0) begin
`endif
      errors++;
      $display("FAIL saturation got hart=%0d geenHart=%b", hart2, geen2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = 0;
    test_reset();
    test_periodic();
    test_refractory();
    test_zero_window();
    test_terminal();
    test_saturation();
    tick(5);
    checks++;
    if (exp_puls.size() != 0) begin
      errors++;
      $display("FAIL beatPuls_pending got %0d outstanding want 0", exp_puls.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
